// File: rtl/router_ingress_port_if.sv
// Byte-stream ingress and crossbar request/grant/egress
// signals of one router input port.
interface router_ingress_port_if;
    logic [7:0] sa;
    logic       sa_valid;
    logic       out_req;
    logic [3:0] out_dest;
    logic       out_grant;
    logic [7:0] out_data;
    logic       out_valid;

    modport master (
        input  sa, sa_valid, out_grant,
        output out_req, out_dest, out_data, out_valid
    );

    modport slave (
        output sa, sa_valid, out_grant,
        input  out_req, out_dest, out_data, out_valid
    );
endinterface

// File: rtl/router_ingress_port.sv
// Store-and-forward ingress stage: parses packets into a byte FIFO,
// releases complete packets to the crossbar via request/grant.
module router_ingress_port #(
    parameter int DEPTH      = 64,
    parameter int DESC_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    router_ingress_port_if.master bus,
    input  logic                  cnt_clr,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int DPW = DAW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [2:0] {
        W_WAIT_GAP, W_IDLE, W_HDR, W_BODY, W_DISCARD
    } wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_XFER} rstate_e;
    typedef struct packed {
        logic [1:0] port;
        logic [7:0] len;
    } desc_t;

    wstate_e        ws_q, ws_d;
    rstate_e        rs_q, rs_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  wr_commit_q, wr_commit_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DPW-1:0] dwr_q, drd_q;
    logic [1:0]     port_q, port_d;
    logic [7:0]     len_q, len_d, cnt_q, cnt_d;
    logic [7:0]     xcnt_q, xcnt_d;
    logic           hdr2_q, hdr2_d;
    logic           blk_q, blk_d;

    logic [7:0]     mem [DEPTH];
    desc_t          desc [DESC_DEPTH];

    logic           mem_we, push, pop, drop;
    logic           space, desc_full, desc_empty, len_ok;
    logic [PW-1:0]  free;
    logic [AW-1:0]  rd_addr;
    desc_t          head;

    // Speculative writes must never land on unread bytes.
    assign space = !((wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
    assign free  = DEPTH_P - (wr_commit_q - rd_ptr_q);
    assign desc_full  = (dwr_q[DPW-1] != drd_q[DPW-1]) &&
                        (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);
    assign desc_empty = (dwr_q == drd_q);
    assign len_ok = (bus.sa >= 8'd4) &&
                    (16'(bus.sa) <= 16'(DEPTH)) &&
                    (16'(bus.sa) <= 16'(free)) &&
                    !desc_full && !blk_q;
    assign head    = desc[drd_q[DAW-1:0]];
    assign rd_addr = rd_ptr_q[AW-1:0] + AW'(xcnt_q);

    always_comb begin
        ws_d        = ws_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        port_d      = port_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hdr2_d      = hdr2_q;
        blk_d       = blk_q;
        mem_we      = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        case (ws_q)
            W_WAIT_GAP: if (!bus.sa_valid) ws_d = W_IDLE;
            W_IDLE: if (bus.sa_valid) begin
                if (bus.sa >= 8'd1 && bus.sa <= 8'd4) begin
                    mem_we = space;
                    if (space) wr_ptr_d = wr_ptr_q + 1'b1;
                    blk_d  = !space;
                    port_d = 2'(bus.sa - 8'd1);
                    hdr2_d = 1'b0;
                    ws_d   = W_HDR;
                end else begin
                    drop = 1'b1;
                    ws_d = W_DISCARD;
                end
            end
            W_HDR: if (!bus.sa_valid) begin
                drop = 1'b1;
                ws_d = W_IDLE;
            end else begin
                mem_we = space;
                if (space) wr_ptr_d = wr_ptr_q + 1'b1;
                if (!hdr2_q) begin
                    blk_d  = blk_q | !space;
                    hdr2_d = 1'b1;
                end else begin
                    len_d = bus.sa;
                    cnt_d = 8'd3;
                    if (len_ok) begin
                        ws_d = W_BODY;
                    end else begin
                        drop = 1'b1;
                        ws_d = W_DISCARD;
                    end
                end
            end
            W_BODY: if (!bus.sa_valid) begin
                drop = 1'b1;
                ws_d = W_IDLE;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == len_q) begin
                    wr_commit_d = wr_ptr_q + 1'b1;
                    push        = 1'b1;
                    ws_d        = W_WAIT_GAP;
                end
            end
            W_DISCARD: if (!bus.sa_valid) ws_d = W_IDLE;
            default: ws_d = W_WAIT_GAP;
        endcase
        if (drop) wr_ptr_d = wr_commit_q;
    end

    always_comb begin
        rs_d     = rs_q;
        xcnt_d   = xcnt_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        case (rs_q)
            R_IDLE: if (!desc_empty) rs_d = R_REQ;
            R_REQ: if (bus.out_grant) begin
                rs_d   = R_XFER;
                xcnt_d = 8'd0;
            end
            R_XFER: if (xcnt_q == head.len - 8'd1) begin
                pop      = 1'b1;
                rd_ptr_d = rd_ptr_q + PW'(head.len);
                rs_d     = R_IDLE;
            end else begin
                xcnt_d = xcnt_q + 8'd1;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    assign bus.out_req   = (rs_q == R_REQ);
    assign bus.out_valid = (rs_q == R_XFER);
    assign bus.out_dest  = bus.out_req ? (4'd1 << head.port) : 4'd0;
    assign bus.out_data  = bus.out_valid ? mem[rd_addr] : 8'd0;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= bus.sa;
        if (push) desc[dwr_q[DAW-1:0]] <= '{port: port_q, len: len_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_q        <= W_WAIT_GAP;
            rs_q        <= R_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            dwr_q       <= '0;
            drd_q       <= '0;
            port_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            xcnt_q      <= '0;
            hdr2_q      <= 1'b0;
            blk_q       <= 1'b0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            ws_q        <= ws_d;
            rs_q        <= rs_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            port_q      <= port_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xcnt_q      <= xcnt_d;
            hdr2_q      <= hdr2_d;
            blk_q       <= blk_d;
            if (push) dwr_q <= dwr_q + 1'b1;
            if (pop)  drd_q <= drd_q + 1'b1;
            if (cnt_clr)                         pkt_cnt <= '0;
            else if (push && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            if (cnt_clr)                          drop_cnt <= '0;
            else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_router_ingress_port.sv
// Bench for router_ingress_port: packet table plus multi-cycle
// sequences, egress checked against a byte/packet scoreboard.
module tb_router_ingress_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_clr;
    logic [15:0] pkt_cnt, drop_cnt;
    int          checks = 0;
    int          errors = 0;

    router_ingress_port_if bus ();

    router_ingress_port #(.DEPTH(64), .DESC_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dest;
        int         len;
    } pinfo_t;

    typedef struct {
        logic [7:0] da;
        logic [7:0] sab;
        logic [7:0] len;
        int         nb;
        logic [7:0] base;
        bit         acc;
        int         pkt;
        int         drp;
    } rec_t;

    logic [7:0] exp_q [$];
    pinfo_t     pkt_q [$];
    int         run = 0;
    rec_t       tbl [11];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(logic [7:0] da, logic [7:0] sab,
                                         logic [7:0] len, logic [7:0] base,
                                         int k);
        if (k == 0) return da;
        if (k == 1) return sab;
        if (k == 2) return len;
        return base + 8'(k - 3);
    endfunction

    // Egress monitor: request destination, byte order, run length.
    always @(negedge clk) begin
        if (bus.out_req) begin
            if (pkt_q.size() == 0) chk("req_unexpected", 1, 0);
            else chk("out_dest", int'(bus.out_dest), int'(pkt_q[0].dest));
        end
        if (bus.out_valid) begin
            run++;
            if (exp_q.size() == 0) chk("byte_unexpected", int'(bus.out_data), -1);
            else chk("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
        end else if (run > 0) begin
            if (pkt_q.size() == 0) begin
                chk("run_unexpected", run, 0);
            end else begin
                pinfo_t p;
                p = pkt_q.pop_front();
                chk("run_len", run, p.len);
            end
            run = 0;
        end
    end

    task automatic send(logic [7:0] da, logic [7:0] sab, logic [7:0] len,
                        int nb, logic [7:0] base, bit acc);
        if (acc) begin
            pinfo_t p;
            p.dest = 4'd1 << (da - 8'd1);
            p.len  = int'(len);
            pkt_q.push_back(p);
            for (int k = 0; k < int'(len); k++)
                exp_q.push_back(pbyte(da, sab, len, base, k));
        end
        for (int k = 0; k < nb; k++) begin
            bus.sa       = pbyte(da, sab, len, base, k);
            bus.sa_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.sa       = 8'd0;
        bus.sa_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_q.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_pkt", int'(pkt_cnt), 0);
        chk("clr_drop", int'(drop_cnt), 0);
    endtask

    initial begin
        tbl[0]  = '{8'd2, 8'd1, 8'd6,  6,  8'hA0, 1'b1, 1, 0};
        tbl[1]  = '{8'd5, 8'd1, 8'd8,  8,  8'hB0, 1'b0, 1, 1};
        tbl[2]  = '{8'd1, 8'd2, 8'd4,  4,  8'hC0, 1'b1, 2, 1};
        tbl[3]  = '{8'd3, 8'd2, 8'd10, 7,  8'hD0, 1'b0, 2, 2};
        tbl[4]  = '{8'd4, 8'd3, 8'd12, 12, 8'hE0, 1'b1, 3, 2};
        tbl[5]  = '{8'd1, 8'd3, 8'd3,  3,  8'h11, 1'b0, 3, 3};
        tbl[6]  = '{8'd2, 8'd3, 8'd65, 5,  8'h22, 1'b0, 3, 4};
        tbl[7]  = '{8'd0, 8'd3, 8'd6,  6,  8'h33, 1'b0, 3, 5};
        tbl[8]  = '{8'd3, 8'd4, 8'd5,  7,  8'h44, 1'b1, 4, 5};
        tbl[9]  = '{8'd2, 8'd4, 8'd8,  2,  8'h55, 1'b0, 4, 6};
        tbl[10] = '{8'd4, 8'd4, 8'd64, 64, 8'h66, 1'b1, 5, 6};

        reset         = 1'b0;
        cnt_clr       = 1'b0;
        bus.sa        = 8'd0;
        bus.sa_valid  = 1'b0;
        bus.out_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", int'(bus.out_req), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_dest", int'(bus.out_dest), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_pkt", int'(pkt_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].da, tbl[i].sab, tbl[i].len,
                 tbl[i].nb, tbl[i].base, tbl[i].acc);
            drain();
            chk($sformatf("tbl%0d_pkt", i), int'(pkt_cnt), tbl[i].pkt);
            chk($sformatf("tbl%0d_drop", i), int'(drop_cnt), tbl[i].drp);
        end

        // Full buffer: a second packet finds free=0 and is dropped.
        clear_counters();
        bus.out_grant = 1'b0;
        send(8'd2, 8'd7, 8'd64, 64, 8'h10, 1'b1);
        send(8'd1, 8'd7, 8'd4, 4, 8'h20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("full_pkt", int'(pkt_cnt), 1);
        chk("full_drop", int'(drop_cnt), 1);
        chk("full_hold_req", int'(bus.out_req), 1);
        chk("full_no_valid", int'(bus.out_valid), 0);
        bus.out_grant = 1'b1;
        drain();
        send(8'd1, 8'd7, 8'd4, 4, 8'h30, 1'b1);
        drain();
        chk("full_after_pkt", int'(pkt_cnt), 2);
        chk("full_after_drop", int'(drop_cnt), 1);

        // Descriptor FIFO full on the ninth packet.
        clear_counters();
        bus.out_grant = 1'b0;
        for (int i = 0; i < 9; i++)
            send(8'((i % 4) + 1), 8'd9, 8'd4, 4, 8'(8'h40 + i), i < 8);
        chk("desc_pkt", int'(pkt_cnt), 8);
        chk("desc_drop", int'(drop_cnt), 1);
        bus.out_grant = 1'b1;
        drain();
        chk("desc_after_pkt", int'(pkt_cnt), 8);

        // Reset mid-body with sa_valid held across release.
        for (int k = 0; k < 10; k++) begin
            bus.sa       = pbyte(8'd1, 8'd5, 8'd20, 8'h70, k);
            bus.sa_valid = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_req", int'(bus.out_req), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_pkt", int'(pkt_cnt), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.sa       = pbyte(8'd2, 8'd1, 8'd4, 8'h55, k);
            bus.sa_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.sa       = 8'd0;
        bus.sa_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_ignored_pkt", int'(pkt_cnt), 0);
        send(8'd3, 8'd6, 8'd6, 6, 8'h90, 1'b1);
        drain();
        chk("post_rst_pkt", int'(pkt_cnt), 1);
        chk("post_rst_drop", int'(drop_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
